// File: rtl/load_store_queue_if.sv
// rtl/load_store_queue_if.sv - shared types and the dispatch/CDB/LSU bundle of the load/store queue
package lsq_pkg;
  typedef logic [4:0]  rs_tag_t;
  typedef logic [31:0] word32_t;
  // Tag 0 is reserved to mean "operand already present" / "bus idle".
  localparam rs_tag_t NO_VAL = 5'd0;
  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;
endpackage

interface load_store_queue_if;
  import lsq_pkg::*;

  logic    disp_valid_i;
  logic    disp_load_i;
  rs_tag_t disp_tag_i;
  rs_tag_t disp_base_tag_i;
  word32_t disp_base_val_i;
  rs_tag_t disp_data_tag_i;
  word32_t disp_data_val_i;
  word32_t disp_offset_i;
  logic    disp_spec_i;
  logic    full_o;
  cdb_t    cdb_i;
  logic    br_resolved_i;
  logic    br_correct_i;
  logic    lsu_read_i;
  logic    lsu_empty_o;
  logic    lsu_load_o;
  word32_t lsu_eff_addr_o;
  word32_t lsu_st_data_o;
  rs_tag_t lsu_ld_tag_o;
  logic    lsu_instr_ready_o;
  logic    lsu_specultative_o;
  logic    lsu_corr_pred_o;

  modport master (
    output disp_valid_i, disp_load_i, disp_tag_i, disp_base_tag_i, disp_base_val_i,
           disp_data_tag_i, disp_data_val_i, disp_offset_i, disp_spec_i,
           cdb_i, br_resolved_i, br_correct_i, lsu_read_i,
    input  full_o, lsu_empty_o, lsu_load_o, lsu_eff_addr_o, lsu_st_data_o,
           lsu_ld_tag_o, lsu_instr_ready_o, lsu_specultative_o, lsu_corr_pred_o
  );

  modport slave (
    input  disp_valid_i, disp_load_i, disp_tag_i, disp_base_tag_i, disp_base_val_i,
           disp_data_tag_i, disp_data_val_i, disp_offset_i, disp_spec_i,
           cdb_i, br_resolved_i, br_correct_i, lsu_read_i,
    output full_o, lsu_empty_o, lsu_load_o, lsu_eff_addr_o, lsu_st_data_o,
           lsu_ld_tag_o, lsu_instr_ready_o, lsu_specultative_o, lsu_corr_pred_o
  );
endinterface

// File: rtl/load_store_queue.sv
// rtl/load_store_queue.sv - in-order load/store queue with CDB snoop and branch squash
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic              clk_i,
  input logic              reset_i,
  load_store_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]   head, tail;
  logic [AW:0]     count;
  logic [DEPTH-1:0] valid, load, spec, squash;
  rs_tag_t ld_tag   [DEPTH];
  rs_tag_t base_tag [DEPTH];
  rs_tag_t data_tag [DEPTH];
  word32_t offset   [DEPTH];
  word32_t addr     [DEPTH];
  word32_t data     [DEPTH];

  logic    empty, push, pop, cdb_live;
  rs_tag_t new_base_tag, new_data_tag;
  word32_t new_base_val, new_data_val;

  assign empty       = (count == '0);
  assign bus.full_o  = (count == FULL_COUNT);
  assign push        = bus.disp_valid_i && !bus.full_o;
  assign pop         = bus.lsu_read_i && !empty;
  assign cdb_live    = (bus.cdb_i.tag != NO_VAL);

  // Operand resolution for the entry being written, including same-cycle CDB bypass.
  always_comb begin
    new_base_tag = bus.disp_base_tag_i;
    new_base_val = bus.disp_base_val_i;
    new_data_tag = NO_VAL;
    new_data_val = '0;
    if (cdb_live && bus.cdb_i.tag == bus.disp_base_tag_i) begin
      new_base_tag = NO_VAL;
      new_base_val = bus.cdb_i.val;
    end
    if (!bus.disp_load_i) begin
      new_data_tag = bus.disp_data_tag_i;
      new_data_val = bus.disp_data_val_i;
      if (cdb_live && bus.cdb_i.tag == bus.disp_data_tag_i) begin
        new_data_tag = NO_VAL;
        new_data_val = bus.cdb_i.val;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i]) begin
          if (cdb_live && base_tag[i] == bus.cdb_i.tag) begin
            addr[i]     <= bus.cdb_i.val + offset[i];
            base_tag[i] <= NO_VAL;
          end
          if (cdb_live && data_tag[i] == bus.cdb_i.tag) begin
            data[i]     <= bus.cdb_i.val;
            data_tag[i] <= NO_VAL;
          end
          if (bus.br_resolved_i) begin
            if (bus.br_correct_i) spec[i] <= 1'b0;
            else if (spec[i])     squash[i] <= 1'b1;
          end
        end
      end

      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end

      if (push) begin
        valid[tail]    <= 1'b1;
        load[tail]     <= bus.disp_load_i;
        ld_tag[tail]   <= bus.disp_load_i ? bus.disp_tag_i : NO_VAL;
        base_tag[tail] <= new_base_tag;
        offset[tail]   <= bus.disp_offset_i;
        addr[tail]     <= (new_base_tag == NO_VAL) ? new_base_val + bus.disp_offset_i : '0;
        data_tag[tail] <= new_data_tag;
        data[tail]     <= new_data_val;
        spec[tail]     <= bus.disp_spec_i && !(bus.br_resolved_i && bus.br_correct_i);
        squash[tail]   <= bus.disp_spec_i && bus.br_resolved_i && !bus.br_correct_i;
        tail           <= tail + 1'b1;
      end

      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign bus.lsu_empty_o        = empty;
  assign bus.lsu_load_o         = !empty && load[head];
  assign bus.lsu_eff_addr_o     = empty ? '0 : addr[head];
  assign bus.lsu_st_data_o      = empty ? '0 : data[head];
  assign bus.lsu_ld_tag_o       = empty ? NO_VAL : ld_tag[head];
  assign bus.lsu_specultative_o = !empty && spec[head];
  assign bus.lsu_corr_pred_o    = empty || !squash[head];
  // A squashed head is ready regardless of operands so it can be discarded.
  assign bus.lsu_instr_ready_o  = !empty && valid[head] &&
                                  (squash[head] || (base_tag[head] == NO_VAL &&
                                   data_tag[head] == NO_VAL && !spec[head]));
endmodule

// File: doc/load_store_queue.md
# load_store_queue

In-order queue of memory operations between dispatch and the `dmem_read_write_unit`.

- Accepts dispatched loads and stores.
- Snoops the CDB for missing base and store-data operands.
- Computes the effective address as base + offset.
- Tracks branch speculation per entry.
- Presents the head entry on the `lsu_*` interface; the downstream unit pops it with `lsu_read_i`.

## Interface
- `DEPTH`, default 8: number of entries; must be a power of two and ≥2.

Ports (clock and reset first):
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_i`  in  1  one clock; reset is synchronous and active-low.
- `disp_valid_i`  in  1  dispatch request this cycle.
- `disp_load_i`  in  1  1 = load, 0 = store.
- `disp_tag_i`  in  rs_tag_t  destination tag of a load; don't-care for a store.
- `disp_base_tag_i`  in  rs_tag_t  producer tag of the base operand; NO_VAL = value present.
- `disp_base_val_i`  in  word32_t  base value when the tag is NO_VAL.
- `disp_data_tag_i`  in  rs_tag_t  producer tag of the store data; ignored for loads.
- `disp_data_val_i`  in  word32_t  store data when the tag is NO_VAL.
- `disp_offset_i`  in  word32_t  sign-extended immediate offset.
- `disp_spec_i`  in  1  instruction sits under an unresolved branch.
- `full_o`  out  1  queue holds DEPTH entries.
- `cdb_i`  in  cdb_t  result broadcast (`.tag`, `.val`); `.tag == NO_VAL` = idle.
- `br_resolved_i`  in  1  outstanding branch resolves this cycle.
- `br_correct_i`  in  1  prediction was correct; qualified by `br_resolved_i`.
- `lsu_read_i`  in  1  downstream pops the head.
- `lsu_empty_o`  out  1  no valid entries.
- `lsu_load_o`  out  1  head is a load.
- `lsu_eff_addr_o`  out  word32_t  head effective address.
- `lsu_st_data_o`  out  word32_t  head store data.
- `lsu_ld_tag_o`  out  rs_tag_t  head load tag; NO_VAL for a store.
- `lsu_instr_ready_o`  out  1  head may be popped.
- `lsu_specultative_o`  out  1  head spec bit.
- `lsu_corr_pred_o`  out  1  0 when the head is squashed.

## Operation

Storage:
- Circular buffer: head pointer, tail pointer, count (log2(DEPTH)+1 bits).
- Each entry holds: `valid`, `load`, `ld_tag`, `base_tag`, `offset`, `addr`, `data_tag`, `data`, `spec`, `squash`.

Dispatch:
- Accepted when `disp_valid_i` and `!full_o`; ignored when full, even if a pop happens the same cycle.
- A ready base sets `addr = base + offset`; addition is modulo 2^32 with no overflow flag.
- Loads: `data_tag` is written NO_VAL and `ld_tag = disp_tag_i`.
- Stores: `ld_tag` is written NO_VAL.
- Same-cycle bypass: if `cdb_i.tag` is not NO_VAL and equals `disp_base_tag_i` or `disp_data_tag_i`, the operand is captured from `cdb_i.val` in the written entry.

CDB snoop, every valid entry, every cycle:
- `base_tag` match: `addr <= cdb_i.val + offset`; `base_tag <= NO_VAL`.
- `data_tag` match: `data <= cdb_i.val`; `data_tag <= NO_VAL`.
- Both fields may match in the same cycle.

Speculation, on `br_resolved_i`:
- Correct: clear `spec` on all valid entries and on any entry dispatched that cycle.
- Incorrect: set `squash` on every valid or same-cycle-dispatched entry with `spec`=1.
- Squashed entries keep `spec`=1.

Head outputs are combinational from the head entry:
- `lsu_instr_ready_o` = valid & (squash | (base_tag==NO_VAL & data_tag==NO_VAL & !spec)).
- `lsu_specultative_o` = spec.
- `lsu_corr_pred_o` = !squash.
- When the queue is empty, all data outputs are 0, `lsu_ld_tag_o` = NO_VAL, and ready/spec = 0.

Pop:
- `lsu_read_i` with `!lsu_empty_o` frees the head and advances the head pointer.
- A pop while empty is ignored.
- A squashed head becomes ready, so downstream pops it and discards it without a memory access.
- `lsu_read_i` while the head is not ready is a protocol violation; the queue pops anyway.

Simultaneous events:
- Push and pop in the same cycle (not full): count unchanged and both pointers advance.
- CDB capture and resolution both apply in the same cycle.

## Timing
- Reset (`reset_i`=0 at an edge): count=0, pointers=0, all `valid`=0.
  - `lsu_empty_o`=1, `full_o`=0, `lsu_instr_ready_o`=0, all other outputs at their empty values.
- Reset mid-operation discards all entries.
- Dispatch in cycle N: entry is visible at the head and counted in `full_o` from cycle N+1.
  - With all operands ready and `spec`=0, `lsu_instr_ready_o`=1 in N+1.
- CDB broadcast in cycle N: the dependent head becomes ready in N+1.
- Resolution in cycle N: effect is visible at the outputs in N+1.
- Pop in cycle N: the next entry is presented in N+1.
- Pointers wrap modulo DEPTH.
- `full_o` depends on count only and is registered-state derived, with no combinational path from any input.

## Test plan
- Reset then idle: `lsu_empty_o`=1, `full_o`=0, `lsu_instr_ready_o`=0 for 10 cycles.
- Load dispatch with base ready (0x1000), offset 0xFFFFFFFC, tag 3:
  - next cycle: head `addr`=0x0FFC, `lsu_load_o`=1, `lsu_ld_tag_o`=3, ready=1.
  - pop → empty.
- Store with base tag 5 and data tag 6 pending:
  - ready=0 until CDB {5,0x20} and then {6,0xAB} arrive; offset 4 gives `addr`=0x24, data=0xAB.
  - ready asserts the cycle after tag 6.
  - Repeat with both broadcasts in the dispatch cycle (bypass): ready the next cycle.
- Fill DEPTH entries:
  - `full_o`=1 and a further dispatch is dropped.
  - Simultaneous pop+push when count=DEPTH-1 keeps count.
  - Drain 2×DEPTH ops across pointer wrap; FIFO order is preserved.
- Two spec loads behind one non-spec store:
  - `br_correct_i`=0 → both show spec=1, corr_pred=0, ready=1, and are popped.
  - Repeat with correct prediction → spec clears.
- Resolution in the same cycle as a spec dispatch:
  - the new entry is squashed when incorrect and cleared when correct.
  - Reset asserted with 3 entries queued → empty next cycle.
